nw_corner_router: RTL and testbench
===================================

// Module: nw_corner_router
// PURPOSE
//  Northwest-corner 3-port mesh NoC router: ports South, East, Local (no North/West links).
//  Buffers single-flit packets per input and routes them dimension-ordered (X then Y).
//  Round-robin arbitrates each output among competing inputs.
//  Sits at mesh tile (XCOORD,YCOORD); X grows eastward, Y grows southward.
// PARAMETERS
//  XCOORD      4'b0001  this router's X coordinate
//  YCOORD      4'b0001  this router's Y coordinate
//  DATA_W      32       flit width; [31:28]=dest X, [27:24]=dest Y, [23:0]=payload
//  FIFO_DEPTH  4        entries per input FIFO (power of 2, >=2)
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  s_in_data    in   DATA_W  flit arriving from South neighbour
//  s_in_valid   in   1       s_in_data valid
//  s_in_ready   out  1       South input FIFO can accept
//  s_out_data   out  DATA_W  flit sent to South neighbour
//  s_out_valid  out  1       s_out_data valid
//  s_out_ready  in   1       South neighbour accepts
//  e_in_*/e_out_*  same six signals for the East port
//  l_in_*/l_out_*  same six signals for the Local (PE) port
//  route_err    out  1       1-cycle pulse: dropped flit with unreachable dest
// BEHAVIOUR
//  Reset: all FIFOs empty, *_in_ready=0 while rst_n low then 1, *_out_valid=0,
//   *_out_data=0, route_err=0, RR pointers point to lowest-index input (S=0,E=1,L=2).
//  Handshake (all ports): transfer when valid&&ready on a rising edge. A sender holds
//   data stable while valid&&!ready; valid never drops without a transfer.
//  in_ready = FIFO not full (registered-free, combinational from count). Write on full is
//   impossible by protocol; if attempted, flit ignored.
//  Routing of FIFO head (dx=flit[31:28], dy=flit[27:24]):
//   dx>XCOORD -> East; else dx==XCOORD & dy>YCOORD -> South; dx==XCOORD & dy==YCOORD -> Local;
//   dx<XCOORD or dy<YCOORD -> unreachable: head popped, flit dropped, route_err pulses.
//  U-turns (East->East, South->South) are not possible under XY routing; treat as route above.
//  Output stage: one register per output. Arbiter grants when register empty or being
//   drained this cycle (out_valid && out_ready). Grant pops head from granted FIFO and loads
//   register next edge. Full throughput 1 flit/cycle/output.
//  Arbitration: round-robin per output among requesting inputs; pointer advances to
//   granted index+1 (mod 3) after each grant; pointer unchanged when no grant.
//  Latency: flit accepted at edge N on an idle router appears on out_valid after edge N+1
//   (2 cycles input-to-output register). Order preserved per input/output pair.
//  Simultaneous FIFO write and pop on same cycle allowed incl. when full (count unchanged;
//   in_ready still reflects full before pop — no same-cycle bypass).
//  Backpressure: out_ready low stalls register; FIFOs fill; in_ready drops at FIFO_DEPTH.
//  Reset mid-operation: all buffered flits discarded immediately; outputs drop same instant.
//  Head-of-line blocking accepted: a blocked head stalls its whole input FIFO.
// TESTING
//  Local flit dx=3,dy=1 -> appears on e_out_data 2 cycles later, unchanged, e_out_valid=1 one cycle.
//  South flit dx=1,dy=1 payload 24'hABCDEF -> l_out_data=32'h11ABCDEF; East flit dx=1,dy=4 -> s_out.
//  S and E both send to Local every cycle, l_out_ready=1 -> Local outputs alternate S,E,S,E.
//  l_out_ready=0, stream 6 flits S->Local -> s_in_ready low after 4 accepted (+1 in out reg);
//   release ready -> all 5 delivered in order, then remaining one.
//  Local flit dx=0,dy=1 -> no output valid, route_err pulses one cycle, FIFO empties.
//  Assert rst_n low with flits buffered -> all *_out_valid=0 immediately, no flit emerges after.

Source files
------------

// File: rtl/nw_corner_router.sv
// Northwest-corner mesh router with South, East and Local ports. Each input has a flit FIFO;
// the FIFO head is XY-routed and round-robin arbitrated into one register per output.
module nw_corner_router #(
  parameter logic [3:0] XCOORD     = 4'b0001,
  parameter logic [3:0] YCOORD     = 4'b0001,
  parameter int         DATA_W     = 32,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_in_data,
  input  logic              s_in_valid,
  output logic              s_in_ready,
  output logic [DATA_W-1:0] s_out_data,
  output logic              s_out_valid,
  input  logic              s_out_ready,
  input  logic [DATA_W-1:0] e_in_data,
  input  logic              e_in_valid,
  output logic              e_in_ready,
  output logic [DATA_W-1:0] e_out_data,
  output logic              e_out_valid,
  input  logic              e_out_ready,
  input  logic [DATA_W-1:0] l_in_data,
  input  logic              l_in_valid,
  output logic              l_in_ready,
  output logic [DATA_W-1:0] l_out_data,
  output logic              l_out_valid,
  input  logic              l_out_ready,
  output logic              route_err
);
  localparam int NP    = 3;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Port index doubles as input index and output index.
  typedef enum logic [1:0] {
    PORT_S    = 2'd0,
    PORT_E    = 2'd1,
    PORT_L    = 2'd2,
    PORT_NONE = 2'd3
  } port_e;

  function automatic port_e route_of(input logic [7:0] dest);
    logic [3:0] dx;
    logic [3:0] dy;
    dx = dest[7:4];
    dy = dest[3:0];
    if (dx > XCOORD)                        return PORT_E;
    else if (dx == XCOORD && dy > YCOORD)   return PORT_S;
    else if (dx == XCOORD && dy == YCOORD)  return PORT_L;
    else                                    return PORT_NONE;
  endfunction

  logic [DATA_W-1:0]     in_data    [NP];
  logic [NP-1:0]         in_valid;
  logic [NP-1:0]         in_ready;
  logic [NP-1:0]         out_ready;
  logic [NP-1:0]         out_valid;
  logic [DATA_W-1:0]     out_data_q [NP];

  logic [DATA_W-1:0]     mem        [NP][FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr     [NP];
  logic [PTR_W-1:0]      wr_ptr     [NP];
  logic [CNT_W-1:0]      count      [NP];
  logic [DATA_W-1:0]     head       [NP];
  port_e                 route      [NP];
  logic [NP-1:0]         push, pop, drop, nonempty;

  logic [NP-1:0][NP-1:0] grant;     // grant[output][input]
  logic [1:0]            rr_ptr     [NP];
  logic [1:0]            next_ptr   [NP];
  logic [DATA_W-1:0]     sel_data   [NP];

  assign in_data[0] = s_in_data;
  assign in_data[1] = e_in_data;
  assign in_data[2] = l_in_data;
  assign in_valid   = {l_in_valid, e_in_valid, s_in_valid};
  assign out_ready  = {l_out_ready, e_out_ready, s_out_ready};

  assign s_in_ready  = in_ready[0];
  assign e_in_ready  = in_ready[1];
  assign l_in_ready  = in_ready[2];
  assign s_out_valid = out_valid[0];
  assign e_out_valid = out_valid[1];
  assign l_out_valid = out_valid[2];
  assign s_out_data  = out_data_q[0];
  assign e_out_data  = out_data_q[1];
  assign l_out_data  = out_data_q[2];

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      in_ready[i] = rst_n && (count[i] != CNT_W'(FIFO_DEPTH));
      push[i]     = in_valid[i] && in_ready[i];
      nonempty[i] = (count[i] != '0);
      head[i]     = mem[i][rd_ptr[i]];
      route[i]    = nonempty[i] ? route_of(head[i][DATA_W-1 -: 8]) : PORT_NONE;
      drop[i]     = nonempty[i] && (route[i] == PORT_NONE);
    end
  end

  // Search starts at the pointer so the most recently served input is tried last.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    pop   = drop;
    for (int o = 0; o < NP; o++) begin
      next_ptr[o] = rr_ptr[o];
      sel_data[o] = '0;
      found       = 1'b0;
      if (!out_valid[o] || out_ready[o]) begin
        for (int k = 0; k < NP; k++) begin
          idx = (int'(rr_ptr[o]) + k) % NP;
          if (!found && nonempty[idx] && route[idx] == port_e'(o)) begin
            grant[o][idx] = 1'b1;
            pop[idx]      = 1'b1;
            sel_data[o]   = head[idx];
            next_ptr[o]   = 2'((idx + 1) % NP);
            found         = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: FIFO storage has no reset; emptiness lives in count, so clearing pointers discards flits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i];
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) begin
        rd_ptr[i]     <= '0;
        wr_ptr[i]     <= '0;
        count[i]      <= '0;
        rr_ptr[i]     <= '0;
        out_data_q[i] <= '0;
      end
      out_valid <= '0;
      route_err <= 1'b0;
    end else begin
      route_err <= |drop;
      for (int i = 0; i < NP; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: ;
        endcase
      end
      for (int o = 0; o < NP; o++) begin
        if (|grant[o]) begin
          out_valid[o]  <= 1'b1;
          out_data_q[o] <= sel_data[o];
          rr_ptr[o]     <= next_ptr[o];
        end else if (out_ready[o]) begin
          out_valid[o]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nw_corner_router.sv
// Self-checking bench for nw_corner_router: directed scenarios plus a randomized run checked
// against a per-(input,output) ordered flit model.
module tb_nw_corner_router;
  localparam int         DATA_W = 32;
  localparam int         DEPTH  = 4;
  localparam logic [3:0] XC     = 4'd1;
  localparam logic [3:0] YC     = 4'd1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data  [3];
  logic [DATA_W-1:0] out_data [3];
  logic              route_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] exp_q [3][3][$];   // [source][destination], in arrival order
  int                exp_err, seen_err;
  logic [2:0]        acc, delivered;
  logic [DATA_W-1:0] last_out [3];
  string             pn [3] = '{"s", "e", "l"};

  always #5 clk = ~clk;

  nw_corner_router #(.XCOORD(XC), .YCOORD(YC), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_in_data(in_data[0]), .s_in_valid(in_valid[0]), .s_in_ready(in_ready[0]),
    .s_out_data(out_data[0]), .s_out_valid(out_valid[0]), .s_out_ready(out_ready[0]),
    .e_in_data(in_data[1]), .e_in_valid(in_valid[1]), .e_in_ready(in_ready[1]),
    .e_out_data(out_data[1]), .e_out_valid(out_valid[1]), .e_out_ready(out_ready[1]),
    .l_in_data(in_data[2]), .l_in_valid(in_valid[2]), .l_in_ready(in_ready[2]),
    .l_out_data(out_data[2]), .l_out_valid(out_valid[2]), .l_out_ready(out_ready[2]),
    .route_err(route_err)
  );

  // Destination output from the XY rules: 0=S, 1=E, 2=L, -1 unreachable.
  function automatic int model_route(input logic [DATA_W-1:0] f);
    int dx, dy;
    dx = int'(f[31:28]);
    dy = int'(f[27:24]);
    if (dx > int'(XC))                     return 1;
    if (dx == int'(XC) && dy > int'(YC))   return 0;
    if (dx == int'(XC) && dy == int'(YC))  return 2;
    return -1;
  endfunction

  function automatic logic [DATA_W-1:0] gen_flit(input bit allow_err);
    int         kind;
    logic [3:0] dx, dy;
    kind = allow_err ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2));
    case (kind)
      0:       begin dx = 4'd1; dy = 4'($urandom_range(2, 15)); end
      1:       begin dx = 4'($urandom_range(2, 15)); dy = 4'($urandom_range(0, 15)); end
      2:       begin dx = 4'd1; dy = 4'd1; end
      default: if ($urandom_range(0, 1) == 1) begin dx = 4'd0; dy = 4'($urandom_range(0, 15)); end
               else begin dx = 4'd1; dy = 4'd0; end
    endcase
    return {dx, dy, 24'($urandom)};
  endfunction

  function automatic int sb_total();
    int t = 0;
    for (int s = 0; s < 3; s++)
      for (int d = 0; d < 3; d++) t += exp_q[s][d].size();
    return t;
  endfunction

  function automatic void sb_clear();
    for (int s = 0; s < 3; s++)
      for (int d = 0; d < 3; d++) exp_q[s][d].delete();
  endfunction

  // Entered at a negedge with inputs already set; records the handshakes of the coming
  // rising edge, scores deliveries, and returns at the following negedge.
  task automatic step();
    int   r;
    logic found;
    #1;
    acc       = '0;
    delivered = '0;
    if (rst_n) begin
      if (route_err) seen_err++;
      for (int i = 0; i < 3; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          acc[i] = 1'b1;
          r = model_route(in_data[i]);
          if (r < 0) exp_err++;
          else exp_q[i][r].push_back(in_data[i]);
        end
      end
      for (int o = 0; o < 3; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          delivered[o] = 1'b1;
          last_out[o]  = out_data[o];
          found        = 1'b0;
          for (int s = 0; s < 3; s++) begin
            if (!found && exp_q[s][o].size() > 0 && exp_q[s][o][0] === out_data[o]) begin
              void'(exp_q[s][o].pop_front());
              found = 1'b1;
            end
          end
          vectors++;
          if (!found) begin
            miscompares++;
            $display("FAIL sb_%s_out: got %h, required the next pending flit of some input", pn[o], out_data[o]);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 3'b111;
    acc       = '0;
    sb_clear();
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    exp_err  = 0;
    seen_err = 0;
  endtask

  task automatic drain(input int n);
    in_valid  = '0;
    out_ready = 3'b111;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 3'b111;
    for (int i = 0; i < 3; i++) in_data[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (in_ready !== 3'b000) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 000", in_ready); end
    vectors++;
    if (out_valid !== 3'b000) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 000", out_valid); end
    vectors++;
    if ({out_data[0], out_data[1], out_data[2]} !== 96'h0) begin
      miscompares++; $display("FAIL reset_out_data: got %h %h %h, required zeros", out_data[0], out_data[1], out_data[2]);
    end
    vectors++;
    if (route_err !== 1'b0) begin miscompares++; $display("FAIL reset_route_err: got %b, required 0", route_err); end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 3'b111) begin miscompares++; $display("FAIL post_reset_in_ready: got %b, required 111", in_ready); end
    exp_err  = 0;
    seen_err = 0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic [DATA_W-1:0] f;
    f = {4'd3, 4'd1, 24'h5A5A01};
    in_data[2] = f;
    in_valid   = 3'b100;
    out_ready  = 3'b111;
    step();
    in_valid = '0;
    vectors++;
    if (acc[2] !== 1'b1) begin miscompares++; $display("FAIL lat_accept: got %b, required 1", acc[2]); end
    vectors++;
    if (out_valid !== 3'b000) begin miscompares++; $display("FAIL lat_edge_n: got valid %b, required 000", out_valid); end
    step();
    vectors++;
    if (out_valid !== 3'b010 || out_data[1] !== f) begin
      miscompares++; $display("FAIL lat_edge_n1: got valid %b data %h, required 010 %h", out_valid, out_data[1], f);
    end
    step();
    vectors++;
    if (out_valid !== 3'b000) begin miscompares++; $display("FAIL lat_one_cycle: got valid %b, required 000", out_valid); end
  endtask

  task automatic test_routing();
    logic [DATA_W-1:0] fe;
    fe = {4'd1, 4'd4, 24'h13579B};
    in_data[0] = 32'h11ABCDEF;
    in_data[1] = fe;
    in_valid   = 3'b011;
    step();
    in_valid = '0;
    step();
    vectors++;
    if (out_valid[2] !== 1'b1 || out_data[2] !== 32'h11ABCDEF) begin
      miscompares++; $display("FAIL route_s_to_l: got valid %b data %h, required 1 11abcdef", out_valid[2], out_data[2]);
    end
    vectors++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== fe) begin
      miscompares++; $display("FAIL route_e_to_s: got valid %b data %h, required 1 %h", out_valid[0], out_data[0], fe);
    end
    drain(3);
  endtask

  task automatic test_alternation();
    int   seq_s, seq_e;
    logic order [$];
    do_reset();
    seq_s = 0;
    seq_e = 0;
    in_valid = 3'b011;
    for (int c = 0; c < 20; c++) begin
      in_data[0] = {8'h11, 1'b0, 23'(seq_s)};
      in_data[1] = {8'h11, 1'b1, 23'(seq_e)};
      step();
      if (acc[0]) seq_s++;
      if (acc[1]) seq_e++;
      if (delivered[2]) order.push_back(last_out[2][23]);
    end
    in_valid = '0;
    vectors++;
    if (order.size() < 8) begin
      miscompares++; $display("FAIL rr_count: got %0d local outputs, required at least 8", order.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        vectors++;
        if (order[k] !== 1'(k % 2)) begin
          miscompares++; $display("FAIL rr_order[%0d]: got source %b, required %b", k, order[k], 1'(k % 2));
        end
      end
    end
    drain(12);
  endtask

  task automatic test_backpressure();
    int sent;
    int seen [$];
    sent      = 0;
    in_valid  = '0;
    out_ready = 3'b011;
    for (int c = 0; c < 10; c++) begin
      in_valid[0] = (sent < 6);
      in_data[0]  = {8'h11, 8'h50, 16'(sent)};
      step();
      if (acc[0]) sent++;
    end
    vectors++;
    if (sent != 5) begin miscompares++; $display("FAIL bp_accepted: got %0d, required 5", sent); end
    vectors++;
    if (in_ready[0] !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b, required 0", in_ready[0]); end
    vectors++;
    if (out_valid[2] !== 1'b1) begin miscompares++; $display("FAIL bp_out_held: got %b, required 1", out_valid[2]); end
    out_ready[2] = 1'b1;
    for (int c = 0; c < 40 && seen.size() < 6; c++) begin
      in_valid[0] = (sent < 6);
      in_data[0]  = {8'h11, 8'h50, 16'(sent)};
      step();
      if (acc[0]) sent++;
      if (delivered[2]) seen.push_back(int'(last_out[2][15:0]));
    end
    in_valid = '0;
    vectors++;
    if (seen.size() != 6) begin miscompares++; $display("FAIL bp_delivered: got %0d, required 6", seen.size()); end
    for (int k = 0; k < seen.size(); k++) begin
      vectors++;
      if (seen[k] != k) begin miscompares++; $display("FAIL bp_order[%0d]: got seq %0d, required %0d", k, seen[k], k); end
    end
    drain(3);
  endtask

  task automatic test_route_err();
    int pulses, valids;
    logic [DATA_W-1:0] f;
    pulses = 0;
    valids = 0;
    in_data[2] = {4'd0, 4'd1, 24'h0BAD00};
    in_valid   = 3'b100;
    out_ready  = 3'b111;
    step();
    in_valid = '0;
    for (int c = 0; c < 5; c++) begin
      if (route_err === 1'b1) pulses++;
      if (out_valid !== 3'b000) valids++;
      step();
    end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL err_pulse: got %0d cycles high, required 1", pulses); end
    vectors++;
    if (valids != 0) begin miscompares++; $display("FAIL err_no_output: got %0d valid cycles, required 0", valids); end
    f = {4'd1, 4'd1, 24'h600D01};
    in_data[2] = f;
    in_valid   = 3'b100;
    step();
    in_valid = '0;
    step();
    vectors++;
    if (out_valid[2] !== 1'b1 || out_data[2] !== f) begin
      miscompares++; $display("FAIL err_fifo_empty: got valid %b data %h, required 1 %h", out_valid[2], out_data[2], f);
    end
    drain(3);
  endtask

  task automatic test_reset_midop();
    int valids;
    valids    = 0;
    out_ready = 3'b000;
    in_valid  = '0;
    acc       = '0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!(in_valid[i] && !acc[i])) begin
          in_valid[i] = 1'b1;
          in_data[i]  = gen_flit(1'b0);
        end
      end
      step();
    end
    vectors++;
    if (out_valid === 3'b000) begin miscompares++; $display("FAIL midrst_loaded: got valid %b, required nonzero", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 3'b000 || in_ready !== 3'b000) begin
      miscompares++; $display("FAIL midrst_immediate: got valid %b ready %b, required 000 000", out_valid, in_ready);
    end
    sb_clear();
    in_valid = '0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 3'b111;
    exp_err   = 0;
    seen_err  = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid !== 3'b000) valids++;
      step();
    end
    vectors++;
    if (valids != 0) begin miscompares++; $display("FAIL midrst_no_leftover: got %0d valid cycles, required 0", valids); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!(in_valid[i] && !acc[i])) begin
          in_valid[i] = ($urandom_range(0, 99) < 60);
          in_data[i]  = gen_flit(i == 2);
        end
      end
      out_ready = 3'($urandom);
      step();
    end
    out_ready = 3'b111;
    for (int c = 0; c < 400 && !(in_valid == 3'b000 && out_valid == 3'b000 && sb_total() == 0); c++) begin
      for (int i = 0; i < 3; i++) if (acc[i]) in_valid[i] = 1'b0;
      step();
    end
    in_valid = '0;
    repeat (3) step();
    vectors++;
    if (sb_total() != 0) begin miscompares++; $display("FAIL rand_drain: got %0d flits undelivered, required 0", sb_total()); end
    vectors++;
    if (seen_err != exp_err) begin miscompares++; $display("FAIL rand_route_err: got %0d pulses, required %0d", seen_err, exp_err); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_routing();
    test_alternation();
    test_backpressure();
    test_route_err();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
